// File: rtl/nn_pkg.sv
// Shared definitions for the layer-1 pooling stage: state encodings and
// helpers that size the pixel counters from the feature-map dimensions.
package nn_pkg;

  // Pooling FSM encodings (2-bit).
  localparam logic [1:0] POOL_S_ROW_A = 2'd0;
  localparam logic [1:0] POOL_S_ROW_B = 2'd1;
  localparam logic [1:0] POOL_S_SKIP  = 2'd2;

  typedef enum logic [1:0] {
    S_ROW_A = POOL_S_ROW_A,
    S_ROW_B = POOL_S_ROW_B,
    S_SKIP  = POOL_S_SKIP
  } pool_state_e;

  // Ceiling log2 of value; 0 for value <= 1.
  function automatic int clog2_f(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // Width of a counter/address that indexes 0..count-1, never below 1 bit.
  function automatic int cnt_width_f(input int count);
    int w;
    w = clog2_f(count);
    return (w < 1) ? 1 : w;
  endfunction

  // Default layer-1 geometry (28x28 image through a 5x5 conv).
  localparam int POOL_IMG_W = 24;
  localparam int POOL_IMG_H = 24;
  localparam int POOL_COL_W = cnt_width_f(POOL_IMG_W);
  localparam int POOL_ROW_W = cnt_width_f(POOL_IMG_H);

endpackage

// File: rtl/maxpool_lbuf.sv
// Half-width line buffer for the 2x2 max-pool: holds the horizontal maxima
// of the upper row of each window pair. One write port, one asynchronous
// read port, no reset (every entry is written before it is read).
module maxpool_lbuf #(
  parameter int N     = 16,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem_q [DEPTH];

  // Write the upper-row horizontal maximum into its slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool between the layer-1 conv unit and the
// next stage. Raster-order input, one pooled pixel per window in raster
// order, half-width line buffer. Odd trailing row/column are dropped.
// Optional build macro MAXPOOL_SIGNED_EN: when defined, comparisons are
// two's-complement signed; otherwise unsigned.
module maxpool2x2_stream
  import nn_pkg::*;
#(
  parameter int N     = 16,
  parameter int IMG_W = POOL_IMG_W,
  parameter int IMG_H = POOL_IMG_H
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         din_vld,
  output logic [N-1:0] dout,
  output logic         dout_vld,
  output logic         frame_done
);

  localparam int COL_W    = cnt_width_f(IMG_W);
  localparam int ROW_W    = cnt_width_f(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = cnt_width_f(LB_DEPTH);
  localparam bit H_ODD    = (IMG_H % 2) != 0;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  // Row index of the second row of the last complete row pair when IMG_H is odd.
  localparam logic [ROW_W-1:0] ROW_SKIP = ROW_W'(IMG_H - 2);

  // Larger of two pixels; ties return either (they are equal).
  function automatic logic [N-1:0] pool_max(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  pool_state_e      state_q, state_d;
  logic [N-1:0]     h_reg_q, h_reg_d;
  logic [N-1:0]     dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             frame_done_q, frame_done_d;

  logic             last_col_s;
  logic             last_row_s;
  logic             lbuf_we_s;
  logic [N-1:0]     lbuf_wdata_s;
  logic [N-1:0]     lbuf_rdata_s;
  logic [LB_AW-1:0] lbuf_addr_s;

  assign last_col_s  = (col_q == COL_LAST);
  assign last_row_s  = (row_q == ROW_LAST);
  // Both pixels of a window column pair share one line-buffer slot.
  assign lbuf_addr_s = LB_AW'(col_q >> 1);

  maxpool_lbuf #(
    .N     (N),
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_lbuf (
    .clk   (clk),
    .we    (lbuf_we_s),
    .waddr (lbuf_addr_s),
    .wdata (lbuf_wdata_s),
    .raddr (lbuf_addr_s),
    .rdata (lbuf_rdata_s)
  );

  // Next-state: raster counters, row-pair FSM, line-buffer write and pooled output.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    state_d      = state_q;
    h_reg_d      = h_reg_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    frame_done_d = 1'b0;
    lbuf_we_s    = 1'b0;
    lbuf_wdata_s = '0;
    if (din_vld) begin
      if (last_col_s) begin
        col_d = '0;
        if (last_row_s) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end else begin
        col_d = col_q + COL_ONE;
        row_d = row_q;
      end
      frame_done_d = last_col_s && last_row_s;
      case (state_q)
        S_ROW_A: begin
          if (col_q[0] == 1'b0) begin
            h_reg_d = din;
          end else begin
            lbuf_we_s    = 1'b1;
            lbuf_wdata_s = pool_max(h_reg_q, din);
          end
          if (last_col_s) begin
            state_d = S_ROW_B;
          end else begin
            state_d = S_ROW_A;
          end
        end
        S_ROW_B: begin
          if (col_q[0] == 1'b0) begin
            h_reg_d = din;
          end else begin
            dout_d     = pool_max(lbuf_rdata_s, pool_max(h_reg_q, din));
            dout_vld_d = 1'b1;
          end
          if (last_col_s && !last_row_s && H_ODD && (row_q == ROW_SKIP)) begin
            state_d = S_SKIP;
          end else if (last_col_s) begin
            state_d = S_ROW_A;
          end else begin
            state_d = S_ROW_B;
          end
        end
        S_SKIP: begin
          if (last_col_s && last_row_s) begin
            state_d = S_ROW_A;
          end else begin
            state_d = S_SKIP;
          end
        end
        default: begin
          state_d = S_ROW_A;
        end
      endcase
    end else begin
      col_d   = col_q;
      row_d   = row_q;
      state_d = state_q;
    end
  end

  // State and output registers; reset drops any partial window immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= S_ROW_A;
      h_reg_q      <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      h_reg_q      <= h_reg_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: three instances (4x4, 5x5,
// 24x24) driven with directed and random frames; expectations come from a
// frame-level reference (store pixels, max over each complete 2x2 window).
module tb_maxpool2x2_stream;

  localparam int NI     = 3;
  localparam int MAXPIX = 576;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        vld_i [NI];
  logic [15:0] dout_o [NI];
  logic        dv_o [NI];
  logic        fd_o [NI];

  int wd [NI] = '{4, 5, 24};
  int ht [NI] = '{4, 5, 24};

  int          n_assert = 0;
  int          n_fail   = 0;
  int          pos [NI];
  logic [15:0] fb [NI][MAXPIX];
  logic [15:0] last_out [NI];
  int          vld_cnt [NI];
  int          fd_cnt [NI];
  logic [15:0] got [$];

  always #5 clk = ~clk;

  maxpool2x2_stream #(.N(16), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(vld_i[0]),
    .dout(dout_o[0]), .dout_vld(dv_o[0]), .frame_done(fd_o[0]));

  maxpool2x2_stream #(.N(16), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(vld_i[1]),
    .dout(dout_o[1]), .dout_vld(dv_o[1]), .frame_done(fd_o[1]));

  maxpool2x2_stream #(.N(16), .IMG_W(24), .IMG_H(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(vld_i[2]),
    .dout(dout_o[2]), .dout_vld(dv_o[2]), .frame_done(fd_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bmax(input logic [15:0] a, input logic [15:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(a) >= $signed(b)) ? a : b;
`else
    return (a >= b) ? a : b;
`endif
  endfunction

  // One clock: present (v, val) to instance inst, then check its outputs.
  task automatic step(input int inst, input bit v, input logic [15:0] val);
    bit e_vld;
    bit e_fd;
    int w;
    int h;
    int k;
    int r;
    int c;
    e_vld = 1'b0;
    e_fd  = 1'b0;
    w = wd[inst];
    h = ht[inst];
    din = val;
    vld_i[inst] = v;
    if (v) begin
      k = pos[inst];
      r = k / w;
      c = k % w;
      fb[inst][k] = val;
      if ((r % 2 == 1) && (c % 2 == 1) && (r < (h / 2) * 2) && (c < (w / 2) * 2)) begin
        e_vld = 1'b1;
        last_out[inst] = bmax(bmax(fb[inst][k - w - 1], fb[inst][k - w]),
                              bmax(fb[inst][k - 1], val));
      end
      e_fd = (k == w * h - 1);
      pos[inst] = e_fd ? 0 : k + 1;
    end
    @(negedge clk);
    vld_i[inst] = 1'b0;
    check("dout_vld", 32'(dv_o[inst]), 32'(e_vld));
    check("dout", 32'(dout_o[inst]), 32'(last_out[inst]));
    check("frame_done", 32'(fd_o[inst]), 32'(e_fd));
    if (dv_o[inst] === 1'b1) begin
      vld_cnt[inst]++;
      got.push_back(dout_o[inst]);
    end
    if (fd_o[inst] === 1'b1) begin
      fd_cnt[inst]++;
    end
  endtask

  // One reset cycle, optionally with a pixel presented to the 4x4 instance.
  task automatic do_reset(input bit with_pix, input logic [15:0] val);
    rst_n = 1'b0;
    din = val;
    vld_i[0] = with_pix;
    @(negedge clk);
    rst_n = 1'b1;
    vld_i[0] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      pos[i] = 0;
      last_out[i] = 16'h0000;
      check("rst_dout_vld", 32'(dv_o[i]), 32'd0);
      check("rst_frame_done", 32'(fd_o[i]), 32'd0);
      check("rst_dout", 32'(dout_o[i]), 32'd0);
    end
  endtask

  // Full frame: mode 0 ramp, 1 reverse ramp, 2 random 0..127, 3 random 16-bit.
  task automatic run_frame(input int inst, input int mode, input bit gap);
    logic [15:0] v;
    int np;
    np = wd[inst] * ht[inst];
    for (int k = 0; k < np; k++) begin
      case (mode)
        0:       v = 16'(k);
        1:       v = 16'(np - 1 - k);
        2:       v = 16'($urandom_range(0, 127));
        default: v = 16'($urandom);
      endcase
      step(inst, 1'b1, v);
      if (gap) begin
        step(inst, 1'b0, 16'($urandom));
      end
    end
  endtask

  task automatic check_seq4(input string tag, input int off, input logic [15:0] e0,
                            input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      check(tag, 32'(got[off + i]), 32'(e[i]));
    end
  endtask

  task automatic clear_counts();
    got.delete();
    for (int i = 0; i < NI; i++) begin
      vld_cnt[i] = 0;
      fd_cnt[i] = 0;
    end
  endtask

  initial begin
    logic [15:0] sp [16];
    rst_n = 1'b0;
    din = 16'h0000;
    for (int i = 0; i < NI; i++) begin
      vld_i[i] = 1'b0;
      pos[i] = 0;
      last_out[i] = 16'h0000;
    end
    clear_counts();
    do_reset(1'b0, 16'h0000);

    // 4x4 ramp, continuous valid.
    run_frame(0, 0, 1'b0);
    check("ramp4_count", 32'(got.size()), 32'd4);
    check_seq4("ramp4_seq", 0, 16'd5, 16'd7, 16'd13, 16'd15);
    check("ramp4_fd", 32'(fd_cnt[0]), 32'd1);

    // Same frame with alternating bubbles.
    clear_counts();
    run_frame(0, 0, 1'b1);
    check("gap4_count", 32'(got.size()), 32'd4);
    check_seq4("gap4_seq", 0, 16'd5, 16'd7, 16'd13, 16'd15);
    check("gap4_fd", 32'(fd_cnt[0]), 32'd1);

    // 5x5 ramp: trailing row and column discarded.
    clear_counts();
    run_frame(1, 0, 1'b0);
    check("ramp5_count", 32'(got.size()), 32'd4);
    check_seq4("ramp5_seq", 0, 16'd6, 16'd8, 16'd16, 16'd18);
    check("ramp5_fd", 32'(fd_cnt[1]), 32'd1);

    // Back-to-back 4x4 frames, second one descending.
    clear_counts();
    run_frame(0, 0, 1'b0);
    run_frame(0, 1, 1'b0);
    check("b2b_count", 32'(got.size()), 32'd8);
    check_seq4("b2b_seq_a", 0, 16'd5, 16'd7, 16'd13, 16'd15);
    check_seq4("b2b_seq_b", 4, 16'd15, 16'd13, 16'd7, 16'd5);
    check("b2b_fd", 32'(fd_cnt[0]), 32'd2);

    // Abort: five pixels, sixth presented during reset, then a clean frame.
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b1, 16'(k));
    end
    do_reset(1'b1, 16'd5);
    check("abort_none", 32'(got.size()), 32'd0);
    run_frame(0, 0, 1'b0);
    check("abort_count", 32'(got.size()), 32'd4);
    check_seq4("abort_seq", 0, 16'd5, 16'd7, 16'd13, 16'd15);
    check("abort_fd", 32'(fd_cnt[0]), 32'd1);

    // Negative-valued windows: signedness of the compare.
    clear_counts();
    sp[0] = 16'hFFFD; sp[1] = 16'hFFFF; sp[2] = 16'hFFFF; sp[3] = 16'h0002;
    sp[4] = 16'hFFF9; sp[5] = 16'hFFFE; sp[6] = 16'h0000; sp[7] = 16'h0001;
    for (int k = 8; k < 16; k++) begin
      sp[k] = 16'($urandom_range(0, 127));
    end
    for (int k = 0; k < 16; k++) begin
      step(0, 1'b1, sp[k]);
    end
    check("sign_count", 32'(got.size()), 32'd4);
    check("sign_win0", 32'(got[0]), 32'h0000FFFF);
`ifdef MAXPOOL_SIGNED_EN
    check("sign_win1", 32'(got[1]), 32'h00000002);
`else
    check("sign_win1", 32'(got[1]), 32'h0000FFFF);
`endif

    // Random frames on every geometry, with and without bubbles.
    clear_counts();
    run_frame(2, 2, 1'b0);
    run_frame(2, 3, 1'b1);
    check("rand24_count", 32'(vld_cnt[2]), 32'd288);
    check("rand24_fd", 32'(fd_cnt[2]), 32'd2);
    run_frame(1, 3, 1'b1);
    run_frame(1, 2, 1'b0);
    check("rand5_count", 32'(vld_cnt[1]), 32'd8);
    check("rand5_fd", 32'(fd_cnt[1]), 32'd2);
    run_frame(0, 3, 1'b0);
    check("rand4_count", 32'(vld_cnt[0]), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
